// File: rtl/led_ctrl_regs.sv
// rtl/led_ctrl_regs.sv - AXI4-Lite register block for the LED blink counter (optional IRQ_CNT via LED_CTRL_IRQ_CNT_EN)
module led_ctrl_regs (
    input  logic        clk100,
    input  logic        rst,
    input  logic [3:0]  s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [3:0]  s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [4:0]  div_o,
    output logic        wren_o,
    input  logic        led_int_i,
    output logic        irq_o
);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t    w_state, w_state_nx;
    r_state_t    r_state, r_state_nx;
    logic        w_hs, r_hs;
    logic        wr_en;
    logic        en, pend, led_int_q;
    logic        pend_set, pend_clr;
    logic [31:0] irq_cnt;
    logic [31:0] rd_mux;

    // Byte lanes above 0 and the address LSBs carry nothing in this map.
    logic        unused_ok;
    assign unused_ok = &{1'b0, s_wdata[31:5], s_wstrb[3:1], s_awaddr[1:0], s_araddr[1:0]};

    assign s_bresp = 2'b00;
    assign s_rresp = 2'b00;

    // Write FSM state register.
    always_ff @(posedge clk100) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nx;
    end

    // Write FSM: accept AW and W only together, then hold the response until taken.
    always_comb begin
        w_state_nx = w_state;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        s_bvalid   = 1'b0;
        w_hs       = 1'b0;
        case (w_state)
            W_IDLE: begin
                w_hs      = s_awvalid & s_wvalid & ~rst;
                s_awready = w_hs;
                s_wready  = w_hs;
                if (w_hs) w_state_nx = W_RESP;
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk100) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nx;
    end

    // Read FSM: single-cycle address accept, then hold data until taken.
    always_comb begin
        r_state_nx = r_state;
        s_arready  = 1'b0;
        s_rvalid   = 1'b0;
        r_hs       = 1'b0;
        case (r_state)
            R_IDLE: begin
                r_hs      = s_arvalid & ~rst;
                s_arready = r_hs;
                if (r_hs) r_state_nx = R_DATA;
            end
            R_DATA: begin
                s_rvalid = 1'b1;
                if (s_rready) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    assign wr_en    = w_hs & s_wstrb[0];
    assign pend_set = led_int_i & ~led_int_q;
    assign pend_clr = wr_en & (s_awaddr[3:2] == 2'd1) & s_wdata[0];

    // CTRL/IRQ_EN storage; wren_o pulses alongside each new divisor.
    always_ff @(posedge clk100) begin
        if (rst) begin
            div_o  <= 5'd0;
            wren_o <= 1'b0;
            en     <= 1'b0;
        end else begin
            wren_o <= 1'b0;
            if (wr_en && s_awaddr[3:2] == 2'd0) begin
                div_o  <= s_wdata[4:0];
                wren_o <= 1'b1;
            end
            if (wr_en && s_awaddr[3:2] == 2'd2) en <= s_wdata[0];
        end
    end

    // Edge detect on led_int_i; a new edge beats a simultaneous W1C.
    always_ff @(posedge clk100) begin
        if (rst) begin
            led_int_q <= 1'b0;
            pend      <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            led_int_q <= led_int_i;
            if (pend_set)      pend <= 1'b1;
            else if (pend_clr) pend <= 1'b0;
            irq_o <= pend & en;
        end
    end

`ifdef LED_CTRL_IRQ_CNT_EN
    // Saturating count of PEND-set events, cleared by any CTRL write.
    always_ff @(posedge clk100) begin
        if (rst)                                     irq_cnt <= 32'd0;
        else if (wr_en && s_awaddr[3:2] == 2'd0)     irq_cnt <= 32'd0;
        else if (pend_set && irq_cnt != 32'hFFFF_FFFF) irq_cnt <= irq_cnt + 32'd1;
    end
`else
    assign irq_cnt = 32'd0;
`endif

    // Read data selection.
    always_comb begin
        rd_mux = 32'd0;
        case (s_araddr[3:2])
            2'd0: rd_mux = {27'd0, div_o};
            2'd1: rd_mux = {30'd0, led_int_i, pend};
            2'd2: rd_mux = {31'd0, en};
            2'd3: rd_mux = irq_cnt;
            default: rd_mux = 32'd0;
        endcase
    end

    // Read data is captured on the address handshake and held until taken.
    always_ff @(posedge clk100) begin
        if (rst)       s_rdata <= 32'd0;
        else if (r_hs) s_rdata <= rd_mux;
    end

endmodule

// File: tb/tb_led_ctrl_regs.sv
// tb/tb_led_ctrl_regs.sv - directed self-checking bench for led_ctrl_regs
module tb_led_ctrl_regs;

    logic        clk100 = 1'b0;
    logic        rst;
    logic [3:0]  s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [3:0]  s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [4:0]  div_o;
    logic        wren_o;
    logic        led_int_i;
    logic        irq_o;

    int errors = 0;
    int checks = 0;

    led_ctrl_regs dut (
        .clk100(clk100), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .div_o(div_o), .wren_o(wren_o), .led_int_i(led_int_i), .irq_o(irq_o)
    );

    always #5 clk100 = ~clk100;

    task automatic step();
        @(posedge clk100);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st,
                            output logic wr_seen, output logic [4:0] div_seen);
        int n;
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        n = 0;
        while (!s_awready && n < 20) begin step(); n++; end
        chk("wr_hs_timeout", 32'(n < 20), 32'd1);
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        wr_seen = wren_o; div_seen = div_o;
        chk("wr_bvalid", 32'(s_bvalid), 32'd1);
        chk("wr_bresp", 32'(s_bresp), 32'd0);
        step();
        s_bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        n = 0;
        while (!s_arready && n < 20) begin step(); n++; end
        chk("rd_hs_timeout", 32'(n < 20), 32'd1);
        step();
        s_arvalid = 1'b0;
        chk("rd_rvalid", 32'(s_rvalid), 32'd1);
        chk("rd_rresp", 32'(s_rresp), 32'd0);
        d = s_rdata;
        step();
        s_rready = 1'b0;
    endtask

    initial begin
        logic        wr;
        logic [4:0]  dv;
        logic [31:0] rd;
        int          hs;
        int          bcnt;
        logic [31:0] cnt_exp;

        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0; led_int_i = 1'b0;
        step(); step();
        chk("rst_div", 32'(div_o), 32'd0);
        chk("rst_wren", 32'(wren_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        #1;
        chk("rst_awready", 32'(s_awready), 32'd0);
        chk("rst_arready", 32'(s_arready), 32'd0);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        step();
        rst = 1'b0;
        step();

        // CTRL write: new divisor with a coincident one-cycle wren pulse
        do_write(4'h0, 32'h5, 4'hF, wr, dv);
        chk("ctrl_wren_pulse", 32'(wr), 32'd1);
        chk("ctrl_div_new", 32'(dv), 32'd5);
        chk("ctrl_wren_drop", 32'(wren_o), 32'd0);
        chk("ctrl_div_hold", 32'(div_o), 32'd5);

        // W alone is not accepted
        s_awaddr = 4'h0; s_wdata = 32'h2; s_wstrb = 4'hF; s_wvalid = 1'b1;
        hs = 0;
        for (int i = 0; i < 2; i++) begin hs += int'(s_awready | s_wready); step(); end
        s_wvalid = 1'b0;
        chk("w_only_no_accept", 32'(hs), 32'd0);
        do_write(4'h0, 32'h2, 4'hF, wr, dv);
        chk("ctrl_div_2", 32'(div_o), 32'd2);

        // AW three cycles ahead of W, response back-pressured for four cycles
        s_awaddr = 4'h0; s_awvalid = 1'b1; s_wvalid = 1'b0; s_bready = 1'b0;
        hs = 0;
        for (int i = 0; i < 3; i++) begin hs += int'(s_awready | s_wready); step(); end
        chk("aw_only_no_accept", 32'(hs), 32'd0);
        s_wdata = 32'h5; s_wstrb = 4'hF; s_wvalid = 1'b1;
        #1;
        hs += int'(s_awready & s_wready);
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 4; i++) begin
            bcnt += int'(s_bvalid);
            hs += int'(s_awready | s_wready);
            step();
        end
        chk("aw_first_single_hs", 32'(hs), 32'd1);
        chk("bvalid_held_4", 32'(bcnt), 32'd4);
        chk("bvalid_still_held", 32'(s_bvalid), 32'd1);
        s_bready = 1'b1;
        step();
        s_bready = 1'b0;
        chk("bvalid_released", 32'(s_bvalid), 32'd0);
        do_read(4'h0, rd);
        chk("rd_ctrl_5", rd, 32'h5);

        // Interrupt path
        do_write(4'h8, 32'h1, 4'hF, wr, dv);
        do_read(4'h8, rd);
        chk("rd_irq_en", rd, 32'h1);
        chk("irq_idle", 32'(irq_o), 32'd0);
        led_int_i = 1'b1;
        step();
        chk("irq_after_1", 32'(irq_o), 32'd0);
        step();
        led_int_i = 1'b0;
        chk("irq_after_2", 32'(irq_o), 32'd1);
        do_read(4'h4, rd);
        chk("rd_status_pend", rd, 32'h1);
        do_read(4'h4, rd);
        chk("rd_status_no_side_effect", rd, 32'h1);
        do_write(4'h4, 32'h1, 4'hF, wr, dv);
        chk("irq_after_w1c", 32'(irq_o), 32'd0);
        do_read(4'h4, rd);
        chk("rd_status_cleared", rd, 32'h0);

        // W1C on the same cycle as a new led_int_i edge: the set wins
        s_awaddr = 4'h4; s_wdata = 32'h1; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1; led_int_i = 1'b1;
        #1;
        chk("w1c_race_hs", 32'(s_awready), 32'd1);
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        step();
        s_bready = 1'b0; led_int_i = 1'b0;
        step();
        do_read(4'h4, rd);
        chk("w1c_race_pend", rd, 32'h1);
        chk("w1c_race_irq", 32'(irq_o), 32'd1);

        // Byte 0 strobe off: no update, no pulse, OKAY
        do_write(4'h0, 32'h1F, 4'hE, wr, dv);
        chk("nostrb_wren", 32'(wr), 32'd0);
        chk("nostrb_div", 32'(dv), 32'd5);

        // Unused CTRL bits read back as zero (this also clears IRQ_CNT)
        do_write(4'h0, 32'hFFFF_FFE5, 4'hF, wr, dv);
        do_read(4'h0, rd);
        chk("rd_ctrl_unused_zero", rd, 32'h5);

        // IRQ_CNT
        for (int i = 0; i < 3; i++) begin
            led_int_i = 1'b1; step();
            led_int_i = 1'b0; step(); step();
        end
`ifdef LED_CTRL_IRQ_CNT_EN
        cnt_exp = 32'd3;
`else
        cnt_exp = 32'd0;
`endif
        do_read(4'hC, rd);
        chk("rd_irq_cnt_3", rd, cnt_exp);
        do_write(4'h0, 32'h7, 4'hF, wr, dv);
        do_read(4'hC, rd);
        chk("rd_irq_cnt_cleared", rd, 32'd0);

        // Reset while a response is pending
        s_awaddr = 4'h8; s_wdata = 32'h0; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("pre_rst_bvalid", 32'(s_bvalid), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_mid_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_mid_div", 32'(div_o), 32'd0);
        chk("rst_mid_irq", 32'(irq_o), 32'd0);
        rst = 1'b0;
        step();
        do_read(4'h4, rd);
        chk("post_rst_status", rd, 32'h0);
        do_read(4'h8, rd);
        chk("post_rst_irq_en", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
